// File: rtl/idex_alu_decode.sv
// ID/EX pipeline stage for RV32I: decodes the ID instruction into an ALU operation,
// selects and extends both ALU operands, and registers the result with a valid bit.
module idex_alu_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            ex_stall,
  input  logic            ex_flush,
  output logic            id_ready,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_operation,
  output logic [XLEN-1:0] ex_input_data1,
  output logic [XLEN-1:0] ex_input_data2,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] shamt;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign funct3 = id_instr[14:12];
  assign funct7 = id_instr[31:25];
  assign shamt  = id_instr[24:20];

  // Immediates: low bits are taken directly, high bits replicate the sign bit.
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_shamt;

  assign imm_i[11:0]     = id_instr[31:20];
  assign imm_s[11:0]     = {id_instr[31:25], id_instr[11:7]};
  assign imm_u           = {id_instr[31:12], 12'b0};
  assign imm_shamt       = {{(XLEN-5){1'b0}}, shamt};

  genvar gi;
  generate
    for (gi = 12; gi < XLEN; gi++) begin : g_sext
      assign imm_i[gi] = id_instr[31];
      assign imm_s[gi] = id_instr[31];
    end
  endgenerate

  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decoded values for the instruction currently in ID
  logic [3:0]      alu_op_next;
  logic [XLEN-1:0] data1_next;
  logic [XLEN-1:0] data2_next;
  logic            reg_write_next;
  logic            mem_read_next;
  logic            mem_write_next;
  logic            branch_next;
  logic            jump_next;
  logic            illegal_next;

  always_comb begin
    alu_op_next    = ALU_AND;
    data1_next     = '0;
    data2_next     = '0;
    reg_write_next = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    branch_next    = 1'b0;
    jump_next      = 1'b0;
    illegal_next   = 1'b0;

    case (opcode)
      OPC_OP: begin
        data1_next     = id_rs1_data;
        data2_next     = id_rs2_data;
        reg_write_next = 1'b1;
        if (funct7 == F7_BASE) begin
          alu_op_next = alu_from_funct3(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_op_next = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_op_next = ALU_SRA;
        end else begin
          illegal_next = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        data1_next     = id_rs1_data;
        data2_next     = imm_i;
        reg_write_next = 1'b1;
        alu_op_next    = alu_from_funct3(funct3);
        // Shift-immediates carry funct7 in imm[11:5]; the operand is just shamt.
        if (funct3 == 3'b001) begin
          data2_next = imm_shamt;
          if (funct7 != F7_BASE) begin
            illegal_next = 1'b1;
          end
        end else if (funct3 == 3'b101) begin
          data2_next = imm_shamt;
          if (funct7 == F7_ALT) begin
            alu_op_next = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            illegal_next = 1'b1;
          end
        end
      end
      OPC_LOAD: begin
        alu_op_next    = ALU_ADD;
        data1_next     = id_rs1_data;
        data2_next     = imm_i;
        mem_read_next  = 1'b1;
        reg_write_next = 1'b1;
      end
      OPC_STORE: begin
        alu_op_next    = ALU_ADD;
        data1_next     = id_rs1_data;
        data2_next     = imm_s;
        mem_write_next = 1'b1;
      end
      OPC_BRANCH: begin
        data1_next  = id_rs1_data;
        data2_next  = id_rs2_data;
        branch_next = 1'b1;
        case (funct3)
          3'b000, 3'b001: alu_op_next = ALU_SUB;
          3'b100, 3'b101: alu_op_next = ALU_SLT;
          3'b110, 3'b111: alu_op_next = ALU_SLTU;
          default:        illegal_next = 1'b1;
        endcase
      end
      OPC_LUI: begin
        alu_op_next    = ALU_ADD;
        data2_next     = imm_u;
        reg_write_next = 1'b1;
      end
      OPC_AUIPC: begin
        alu_op_next    = ALU_ADD;
        data1_next     = id_pc;
        data2_next     = imm_u;
        reg_write_next = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU forms the link address; the jump target is computed elsewhere.
        alu_op_next    = ALU_ADD;
        data1_next     = id_pc;
        data2_next     = XLEN'(4);
        jump_next      = 1'b1;
        reg_write_next = 1'b1;
        if (opcode == OPC_JALR && funct3 != 3'b000) begin
          illegal_next = 1'b1;
        end
      end
      default: begin
        illegal_next = 1'b1;
      end
    endcase

    if (illegal_next) begin
      alu_op_next    = ALU_AND;
      data1_next     = '0;
      data2_next     = '0;
      reg_write_next = 1'b0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      branch_next    = 1'b0;
      jump_next      = 1'b0;
    end

    if (rd == 5'd0) begin
      reg_write_next = 1'b0;
    end
  end

  assign id_ready = !ex_stall;

  // EX register: flush kills control bits, stall holds everything, else load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid         <= 1'b0;
      ex_alu_operation <= '0;
      ex_input_data1   <= '0;
      ex_input_data2   <= '0;
      ex_rs2_data      <= '0;
      ex_rd            <= '0;
      ex_funct3        <= '0;
      ex_reg_write     <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_branch        <= 1'b0;
      ex_jump          <= 1'b0;
      ex_illegal       <= 1'b0;
    end else if (ex_flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid         <= id_valid;
      ex_alu_operation <= alu_op_next;
      ex_input_data1   <= data1_next;
      ex_input_data2   <= data2_next;
      ex_rs2_data      <= id_rs2_data;
      ex_rd            <= rd;
      ex_funct3        <= funct3;
      ex_reg_write     <= reg_write_next & id_valid;
      ex_mem_read      <= mem_read_next  & id_valid;
      ex_mem_write     <= mem_write_next & id_valid;
      ex_branch        <= branch_next    & id_valid;
      ex_jump          <= jump_next      & id_valid;
      ex_illegal       <= illegal_next   & id_valid;
    end
  end

endmodule

// File: tb/tb_idex_alu_decode.sv
// Scoreboard bench for idex_alu_decode: expected EX register images are queued when
// stimulus is driven and compared one cycle later.
module tb_idex_alu_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0;
  logic        ex_stall = 1'b0;
  logic        ex_flush = 1'b0;
  logic        id_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_operation;
  logic [31:0] ex_input_data1;
  logic [31:0] ex_input_data2;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_illegal;

  idex_alu_decode #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_alu_operation(ex_alu_operation), .ex_input_data1(ex_input_data1),
    .ex_input_data2(ex_input_data2), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Image layout: {valid, illegal, reg_write, mem_read, mem_write, branch, jump,
  //                alu_op[3:0], rd[4:0], funct3[2:0], data1, data2, rs2_data}
  localparam logic [6:0] C_V  = 7'b1000000;
  localparam logic [6:0] C_I  = 7'b0100000;
  localparam logic [6:0] C_RW = 7'b0010000;
  localparam logic [6:0] C_MR = 7'b0001000;
  localparam logic [6:0] C_MW = 7'b0000100;
  localparam logic [6:0] C_BR = 7'b0000010;
  localparam logic [6:0] C_J  = 7'b0000001;
  localparam logic [114:0] ALL  = {115{1'b1}};
  localparam logic [114:0] CTRL = {7'h7f, 108'd0};

  typedef struct {
    string        name;
    logic [114:0] v;
    logic [114:0] m;
  } exp_t;

  typedef struct {
    string        name;
    logic         valid;
    logic [31:0]  instr, pc, rs1, rs2;
    logic [114:0] v;
    logic [114:0] m;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [114:0] obs();
    return {ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
            ex_alu_operation, ex_rd, ex_funct3, ex_input_data1, ex_input_data2, ex_rs2_data};
  endfunction

  function automatic logic [114:0] mk(input logic [6:0] ctl, input logic [3:0] op,
                                      input logic [4:0] rd, input logic [2:0] f3,
                                      input logic [31:0] d1, d2, rs2);
    return {ctl, op, rd, f3, d1, d2, rs2};
  endfunction

  function automatic vec_t vec(input string name, input logic valid, input logic [31:0] instr,
                               pc, rs1, rs2, input logic [114:0] v, m);
    vec_t t;
    t.name = name; t.valid = valid; t.instr = instr; t.pc = pc;
    t.rs1 = rs1; t.rs2 = rs2; t.v = v; t.m = m;
    return t;
  endfunction

  task automatic push_exp(input string name, input logic [114:0] v, m);
    exp_t e;
    e.name = name; e.v = v; e.m = m;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, pc, rs1, rs2,
                       input logic stall, flush);
    id_valid = v; id_instr = instr; id_pc = pc;
    id_rs1_data = rs1; id_rs2_data = rs2;
    ex_stall = stall; ex_flush = flush;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_hold: got=%h exp=0", obs());
    end else $display("ok   reset_hold");
    rst_n = 1'b1;
    push_exp("bubble_after_release", '0, CTRL);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ((obs() & e.m) !== (e.v & e.m)) begin
      errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
    end else $display("ok   %s", e.name);
    // Load something, then reset asynchronously in the middle of a stall
    drive(1'b1, 32'h402080B3, 32'h40, 32'd10, 32'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1'b1) begin
      errors++; $display("FAIL load_before_reset: ex_valid=%b exp=1", ex_valid);
    end else $display("ok   load_before_reset");
    ex_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL async_reset: got=%h exp=0", obs());
    end else $display("ok   async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_decode();
    vec_t q[$];
    exp_t e;
    q.push_back(vec("sub", 1, 32'h402080B3, 32'h1000, 32'd10, 32'd3,
                    mk(C_V|C_RW, 4'b0110, 5'd1, 3'd0, 32'd10, 32'd3, 32'd3), ALL));
    q.push_back(vec("addi_neg1", 1, 32'hFFF00293, 32'h1004, 32'h50, 32'h7,
                    mk(C_V|C_RW, 4'b0010, 5'd5, 3'd0, 32'h50, 32'hFFFFFFFF, 32'h7), ALL));
    q.push_back(vec("srai", 1, 32'h4041D193, 32'h1008, 32'h80000000, 32'h9,
                    mk(C_V|C_RW, 4'b1101, 5'd3, 3'd5, 32'h80000000, 32'd4, 32'h9), ALL));
    q.push_back(vec("lui", 1, 32'h123453B7, 32'h100C, 32'hAAAA, 32'hBBBB,
                    mk(C_V|C_RW, 4'b0010, 5'd7, 3'd5, 32'h0, 32'h12345000, 32'hBBBB), ALL));
    q.push_back(vec("bltu", 1, 32'h0020E063, 32'h1010, 32'd1, 32'd2,
                    mk(C_V|C_BR, 4'b1011, 5'd0, 3'd6, 32'd1, 32'd2, 32'd2), ALL));
    q.push_back(vec("add_rd0", 1, 32'h00208033, 32'h1014, 32'd5, 32'd6,
                    mk(C_V, 4'b0010, 5'd0, 3'd0, 32'd5, 32'd6, 32'd6), ALL));
    q.push_back(vec("lw", 1, 32'h0100A183, 32'h1018, 32'h200, 32'h33,
                    mk(C_V|C_RW|C_MR, 4'b0010, 5'd3, 3'd2, 32'h200, 32'd16, 32'h33), ALL));
    q.push_back(vec("sw_negoff", 1, 32'hFE20AE23, 32'h101C, 32'h300, 32'hDEAD,
                    mk(C_V|C_MW, 4'b0010, 5'd28, 3'd2, 32'h300, 32'hFFFFFFFC, 32'hDEAD), ALL));
    q.push_back(vec("jal", 1, 32'h008000EF, 32'h2000, 32'h11, 32'h22,
                    mk(C_V|C_RW|C_J, 4'b0010, 5'd1, 3'd0, 32'h2000, 32'd4, 32'h22), ALL));
    q.push_back(vec("jalr", 1, 32'h000080E7, 32'h2004, 32'h11, 32'h23,
                    mk(C_V|C_RW|C_J, 4'b0010, 5'd1, 3'd0, 32'h2004, 32'd4, 32'h23), ALL));
    q.push_back(vec("auipc", 1, 32'h00001117, 32'h3000, 32'h44, 32'h55,
                    mk(C_V|C_RW, 4'b0010, 5'd2, 3'd1, 32'h3000, 32'h1000, 32'h55), ALL));
    foreach (q[i]) begin
      drive(q[i].valid, q[i].instr, q[i].pc, q[i].rs1, q[i].rs2, 1'b0, 1'b0);
      push_exp(q[i].name, q[i].v, q[i].m);
      @(negedge clk);
      checks++;
      if (id_ready !== 1'b1) begin
        errors++; $display("FAIL id_ready_%s: got=%b exp=1", q[i].name, id_ready);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs() & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
      end else $display("ok   %s", e.name);
    end
  endtask

  task automatic test_illegal_and_bubble();
    vec_t q[$];
    exp_t e;
    q.push_back(vec("ill_opcode", 1, 32'h0000007F, 32'h4000, 32'h1, 32'h2,
                    mk(C_V|C_I, 4'b0, 5'd0, 3'd0, 32'h0, 32'h0, 32'h2), ALL));
    q.push_back(vec("ill_op_f7", 1, 32'h022080B3, 32'h4004, 32'h3, 32'h4,
                    mk(C_V|C_I, 4'b0, 5'd1, 3'd0, 32'h0, 32'h0, 32'h4), ALL));
    q.push_back(vec("ill_branch_f3", 1, 32'h0020A063, 32'h4008, 32'h5, 32'h6,
                    mk(C_V|C_I, 4'b0, 5'd0, 3'd2, 32'h0, 32'h0, 32'h6), ALL));
    q.push_back(vec("ill_jalr_f3", 1, 32'h000090E7, 32'h400C, 32'h7, 32'h8,
                    mk(C_V|C_I, 4'b0, 5'd1, 3'd1, 32'h0, 32'h0, 32'h8), ALL));
    q.push_back(vec("ill_slli_f7", 1, 32'h40311213, 32'h4010, 32'h9, 32'hA,
                    mk(C_V|C_I, 4'b0, 5'd4, 3'd1, 32'h0, 32'h0, 32'hA), ALL));
    q.push_back(vec("bubble_add", 0, 32'h002080B3, 32'h4014, 32'h1, 32'h2, '0, CTRL));
    q.push_back(vec("bubble_illegal", 0, 32'h0000007F, 32'h4018, 32'h1, 32'h2, '0, CTRL));
    foreach (q[i]) begin
      drive(q[i].valid, q[i].instr, q[i].pc, q[i].rs1, q[i].rs2, 1'b0, 1'b0);
      push_exp(q[i].name, q[i].v, q[i].m);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs() & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
      end else $display("ok   %s", e.name);
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    logic [114:0] add_img;
    logic [31:0] junk;
    add_img = mk(C_V|C_RW, 4'b0010, 5'd1, 3'd0, 32'h11, 32'h22, 32'h22);
    drive(1'b1, 32'h002080B3, 32'h100, 32'h11, 32'h22, 1'b0, 1'b0);
    push_exp("add_before_stall", add_img, ALL);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ((obs() & e.m) !== (e.v & e.m)) begin
      errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
    end else $display("ok   %s", e.name);
    for (int c = 0; c < 3; c++) begin
      junk = $urandom;
      drive(1'b1, (c == 0) ? 32'h402080B3 : ((c == 1) ? 32'h0000007F : 32'h0100A183),
            junk, ~junk, junk ^ 32'h5A5A5A5A, 1'b1, 1'b0);
      push_exp($sformatf("stall_hold_%0d", c), add_img, ALL);
      @(negedge clk);
      checks++;
      if (id_ready !== 1'b0) begin
        errors++; $display("FAIL id_ready_stall_%0d: got=%b exp=0", c, id_ready);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs() & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
      end else $display("ok   %s", e.name);
    end
    // Flush wins over stall; then flush alone; then normal flow resumes
    drive(1'b1, 32'h0100A183, 32'h200, 32'h1, 32'h2, 1'b1, 1'b1);
    push_exp("flush_over_stall", '0, CTRL);
    drive(1'b1, 32'h0100A183, 32'h200, 32'h1, 32'h2, 1'b1, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ((obs() & e.m) !== (e.v & e.m)) begin
      errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
    end else $display("ok   %s", e.name);
    drive(1'b1, 32'h0000007F, 32'h204, 32'h1, 32'h2, 1'b0, 1'b1);
    push_exp("flush_alone", '0, CTRL);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ((obs() & e.m) !== (e.v & e.m)) begin
      errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
    end else $display("ok   %s", e.name);
    drive(1'b1, 32'h4041D193, 32'h208, 32'hF0, 32'h3, 1'b0, 1'b0);
    push_exp("resume_srai", mk(C_V|C_RW, 4'b1101, 5'd3, 3'd5, 32'hF0, 32'd4, 32'h3), ALL);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ((obs() & e.m) !== (e.v & e.m)) begin
      errors++; $display("FAIL %s: got=%h exp=%h", e.name, obs() & e.m, e.v & e.m);
    end else $display("ok   %s", e.name);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal_and_bubble();
    test_stall_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
